cache_fill_ctrl: RTL
====================

Name: cache_fill_ctrl

Overview:
Miss-handling sequencer and memory arbiter shared by the I-cache and the D-cache. It accepts block-fill requests from both caches and write-through store requests from the D-cache, and it arbitrates them onto the single pipelined 16-bit memory port. Each fill runs as an 8-beat burst (16 B block, 2 B per beat). Returned words are steered into the requesting cache's data array word by word, and the controller raises a completion pulse that writes the tag and valid bit.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, memory/cache word width
BURST, 8, words per cache block (power of 2); word index width is log2(BURST)

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  synchronous, active-high reset
i_miss  in  1  I-cache miss, level, held until fill_done_i
i_miss_addr  in  ADDR_W  I-cache miss address
d_miss  in  1  D-cache miss, level, held until fill_done_d
d_miss_addr  in  ADDR_W  D-cache miss address
d_store  in  1  D-cache write-through store request, level, held until d_store_ack
d_store_addr  in  ADDR_W  store address
d_store_data  in  DATA_W  store data
mem_en  out  1  memory request valid
mem_wr  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
mem_rvalid  in  1  read data valid; memory is pipelined, one request per cycle, in-order returns
fill_i_wen  out  1  write fill_data into the I-cache data array
fill_d_wen  out  1  write fill_data into the D-cache data array
fill_word  out  log2(BURST)  word index within the block
fill_data  out  DATA_W  fill word (combinational from mem_rdata)
fill_addr  out  ADDR_W  block base address being filled
fill_done_i  out  1  1-cycle pulse: I-cache writes tag and valid
fill_done_d  out  1  1-cycle pulse: D-cache writes tag and valid
d_store_ack  out  1  1-cycle pulse: store issued to memory
i_stall  out  1  stall for the fetch stage
d_stall  out  1  stall for the memory stage

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE; req_cnt, rsp_cnt, fill_addr and target are cleared to 0.
  - All outputs deassert to 0 except the combinational stalls.
  - Memory shares rst, so no stale mem_rvalid arrives after reset.
- Block base: fill_addr = miss_addr & ~(2*BURST-1), i.e. 0xFFF0 by default. Word i is at fill_addr + 2*i. Address bit 0 is ignored.
- States: IDLE, STORE, FILL.
- IDLE: arbitration priority is d_store > d_miss > i_miss, evaluated every cycle.
  - d_store: latch store address and data, go to STORE.
  - d_miss: latch base address, target=D, go to FILL.
  - i_miss: latch base address, target=I, go to FILL.
  - mem_en=0 in IDLE.
- STORE (1 cycle):
  - mem_en=1, mem_wr=1, mem_addr and mem_wdata are the latched values.
  - d_store_ack=1 this cycle, then go to IDLE.
- FILL, issue side:
  - While req_cnt < BURST: mem_en=1, mem_wr=0, mem_addr = fill_addr + {req_cnt,1'b0}, and req_cnt increments.
  - This produces BURST back-to-back reads on consecutive cycles.
  - mem_en=0 after the last issue.
- FILL, return side:
  - On each mem_rvalid: the selected fill_*_wen=1, fill_word=rsp_cnt, fill_data=mem_rdata, and rsp_cnt increments.
  - The non-target wen stays 0.
  - When mem_rvalid arrives with rsp_cnt==BURST-1: fill_done_<target>=1 that same cycle, counters clear, go to IDLE.
- mem_rvalid outside FILL is ignored: no wen, no counter change.
- A fill or store always runs to completion. Deasserting a request mid-operation does not abort it. rst is the only abort.
- Stalls (combinational):
  - i_stall = i_miss & ~fill_done_i.
  - d_stall = (d_miss & ~fill_done_d) | (d_store & ~d_store_ack).
- Simultaneous requests:
  - The loser keeps its stall asserted and is served on the next IDLE cycle.
  - There is at least one IDLE cycle between operations.
  - I-cache starvation is bounded by D-cache traffic only.
- Timing example, memory latency L (rvalid L cycles after issue), request seen in IDLE at cycle 0:
  - Reads are issued at cycles 1..8.
  - rvalid arrives at cycles 1+L..8+L; fill_done is at 8+L; IDLE at 9+L.

Test Plan:
- Single I miss, i_miss_addr=0x1236, L=4 -> reads 0x1230..0x123E issued at cycles 1-8. fill_i_wen at cycles 5-12 with fill_word 0..7. fill_done_i at cycle 12. fill_d_wen never asserts.
- i_miss and d_miss asserted in the same cycle (D addr 0x8004, I addr 0x0040) -> D fill of 0x8000 completes first with fill_done_d, then one IDLE cycle, then I fill of 0x0040. i_stall stays high throughout until fill_done_i.
- d_store (0x2002, 0xBEEF) together with d_miss -> next cycle mem_en=1, mem_wr=1, mem_addr=0x2002, mem_wdata=0xBEEF, d_store_ack=1. The D fill starts on the following IDLE cycle.
- Irregular mem_rvalid (gaps of 0-3 cycles) -> all 8 words are written in order 0..7. fill_done_d fires only on the 8th valid.
- rst asserted at the 5th rvalid of a fill -> next cycle state is IDLE, all outputs 0, counters 0. A new i_miss then yields a full 8-beat fill starting at word 0.
- Spurious mem_rvalid while IDLE -> no fill_*_wen, no fill_done, counters unchanged.

Source files
------------

// File: rtl/cache_fill_ctrl_if.sv
// Cache fill controller bus bundle.
// Cache request side, memory port and fill/stall returns.
interface cache_fill_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int BURST  = 8
);
    localparam int WW = $clog2(BURST);

    logic              i_miss;
    logic [ADDR_W-1:0] i_miss_addr;
    logic              d_miss;
    logic [ADDR_W-1:0] d_miss_addr;
    logic              d_store;
    logic [ADDR_W-1:0] d_store_addr;
    logic [DATA_W-1:0] d_store_data;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;

    logic              fill_i_wen;
    logic              fill_d_wen;
    logic [WW-1:0]     fill_word;
    logic [DATA_W-1:0] fill_data;
    logic [ADDR_W-1:0] fill_addr;
    logic              fill_done_i;
    logic              fill_done_d;
    logic              d_store_ack;
    logic              i_stall;
    logic              d_stall;

    modport master (
        input  i_miss, i_miss_addr, d_miss, d_miss_addr,
        input  d_store, d_store_addr, d_store_data,
        input  mem_rdata, mem_rvalid,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        output fill_i_wen, fill_d_wen, fill_word, fill_data,
        output fill_addr, fill_done_i, fill_done_d,
        output d_store_ack, i_stall, d_stall
    );

    modport slave (
        output i_miss, i_miss_addr, d_miss, d_miss_addr,
        output d_store, d_store_addr, d_store_data,
        output mem_rdata, mem_rvalid,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        input  fill_i_wen, fill_d_wen, fill_word, fill_data,
        input  fill_addr, fill_done_i, fill_done_d,
        input  d_store_ack, i_stall, d_stall
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Miss sequencer and memory arbiter for the I/D caches.
// Burst block fills plus single-beat write-through stores.
module cache_fill_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int BURST  = 8
) (
    input  logic                clk,
    input  logic                rst,
    cache_fill_ctrl_if.master   bus
);
    localparam int WW = $clog2(BURST);
    localparam logic [ADDR_W-1:0] BMASK = ~ADDR_W'(2 * BURST - 1);

    typedef enum logic [1:0] {IDLE, STORE, FILL} state_t;

    state_t            state_q, state_d;
    logic [WW:0]       req_cnt_q, req_cnt_d;
    logic [WW-1:0]     rsp_cnt_q, rsp_cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] st_addr_q, st_addr_d;
    logic [DATA_W-1:0] st_data_q, st_data_d;
    logic              tgt_d_q, tgt_d_d;

    // State and latched request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
            base_q    <= '0;
            st_addr_q <= '0;
            st_data_q <= '0;
            tgt_d_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_cnt_q <= req_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
            base_q    <= base_d;
            st_addr_q <= st_addr_d;
            st_data_q <= st_data_d;
            tgt_d_q   <= tgt_d_d;
        end
    end

    // Arbitration, burst issue and fill return steering
    always_comb begin
        state_d         = state_q;
        req_cnt_d       = req_cnt_q;
        rsp_cnt_d       = rsp_cnt_q;
        base_d          = base_q;
        st_addr_d       = st_addr_q;
        st_data_d       = st_data_q;
        tgt_d_d         = tgt_d_q;
        bus.mem_en      = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.fill_i_wen  = 1'b0;
        bus.fill_d_wen  = 1'b0;
        bus.fill_word   = rsp_cnt_q;
        bus.fill_data   = bus.mem_rdata;
        bus.fill_addr   = base_q;
        bus.fill_done_i = 1'b0;
        bus.fill_done_d = 1'b0;
        bus.d_store_ack = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.d_store) begin
                    st_addr_d = bus.d_store_addr;
                    st_data_d = bus.d_store_data;
                    state_d   = STORE;
                end else if (bus.d_miss) begin
                    base_d  = bus.d_miss_addr & BMASK;
                    tgt_d_d = 1'b1;
                    state_d = FILL;
                end else if (bus.i_miss) begin
                    base_d  = bus.i_miss_addr & BMASK;
                    tgt_d_d = 1'b0;
                    state_d = FILL;
                end
            end
            STORE: begin
                bus.mem_en      = 1'b1;
                bus.mem_wr      = 1'b1;
                bus.mem_addr    = st_addr_q;
                bus.mem_wdata   = st_data_q;
                bus.d_store_ack = 1'b1;
                state_d         = IDLE;
            end
            FILL: begin
                if (req_cnt_q < (WW + 1)'(BURST)) begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = base_q
                                 + ADDR_W'({req_cnt_q[WW-1:0], 1'b0});
                    req_cnt_d    = req_cnt_q + 1'b1;
                end
                if (bus.mem_rvalid) begin
                    bus.fill_i_wen = ~tgt_d_q;
                    bus.fill_d_wen = tgt_d_q;
                    rsp_cnt_d      = rsp_cnt_q + 1'b1;
                    if (rsp_cnt_q == WW'(BURST - 1)) begin
                        bus.fill_done_i = ~tgt_d_q;
                        bus.fill_done_d = tgt_d_q;
                        req_cnt_d       = '0;
                        rsp_cnt_d       = '0;
                        state_d         = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stalls drop in the same cycle the request is satisfied
    assign bus.i_stall = bus.i_miss & ~bus.fill_done_i;
    assign bus.d_stall = (bus.d_miss & ~bus.fill_done_d)
                       | (bus.d_store & ~bus.d_store_ack);
endmodule
